alu_mul_sequencer: RTL

- Multi-cycle controller that computes unsigned XLEN×XLEN multiplication, keeping the low XLEN bits.
- Uses the shared 64-bit ALU in ADD mode, one shift-add step per cycle.
- Sits beside the execute stage and owns the ALU operand and control inputs while busy.
- Valid/ready request and response handshakes with an external sequencer or issue logic.

---
 rtl/alu_mul_sequencer_pkg.sv | 20 ++
 rtl/alu_mul_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer: the ALU opcode
// constants of the execute-stage ALU and the sequencer state type.
package alu_mul_sequencer_pkg;

   localparam int unsigned ALU_CTRL_W = 3;

   // Opcode encodings of the shared execute-stage ALU
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned XLEN x XLEN multiply (low XLEN bits) by shift-add on the shared ALU.
// Optional ALU_MUL_EARLY_TERM_EN ends RUN once the remaining multiplier is zero.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [XLEN-1:0]       req_mcand,
   input  logic [XLEN-1:0]       req_mplier,
   input  logic                  abort,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [XLEN-1:0]       resp_data,
   output logic                  busy,
   output logic [XLEN-1:0]       alu_a,
   output logic [XLEN-1:0]       alu_b,
   output logic [ALU_CTRL_W-1:0] alu_control,
   input  logic [XLEN-1:0]       alu_result
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   mul_state_e       state_q, state_d;
   logic [XLEN-1:0]  acc_q, acc_d;
   logic [XLEN-1:0]  mcand_q, mcand_d;
   logic [XLEN-1:0]  mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_step;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef ALU_MUL_EARLY_TERM_EN
   assign last_step = (cnt_q == CNT_W'(XLEN - 1)) || ((mplier_q >> 1) == '0);
`else
   assign last_step = (cnt_q == CNT_W'(XLEN - 1));
`endif

   // Next-state, datapath update and output decode
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_data   = '0;
      busy        = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_control = ALU_ADD;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !abort) begin
               mcand_d  = req_mcand;
               mplier_d = req_mplier;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            busy  = 1'b1;
            alu_a = acc_q;
            alu_b = mcand_q;
            if (abort) begin
               acc_d   = '0;
               state_d = IDLE;
            end else begin
               if (mplier_q[0]) begin
                  acc_d = alu_result;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (last_step) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            busy       = 1'b1;
            resp_valid = 1'b1;
            resp_data  = acc_q;
            if (abort) begin
               acc_d   = '0;
               state_d = IDLE;
            end else if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
